step_ramp_controller: RTL and testbench

- Trapezoidal motion sequencer for one stepper axis in the quad stepper design.
- Drives the rate word (multiplicand) of the axis's reciprocal rate divider and counts the step pulses that divider returns.
- Per move it ramps the rate from a start rate up to a cruise rate, holds, then ramps down so the last step is issued at start rate; it then stops the divider.
- The quad stepper top level instantiates one controller per axis. The host loads a move and pulses start.

---
 rtl/step_ramp_controller_if.sv | 28 ++
 rtl/step_ramp_controller.sv | 156 +++++++++++++++
 tb/tb_step_ramp_controller.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/step_ramp_controller_if.sv
// Host/divider-facing signal bundle for one step_ramp_controller axis.
// The master side loads moves and feeds divider steps; the slave side is the controller.
interface step_ramp_controller_if #(
    parameter int unsigned RATE_BITS = 32,
    parameter int unsigned STEP_BITS = 32
);
    logic                 start;
    logic                 stop;
    logic [STEP_BITS-1:0] step_count;
    logic [RATE_BITS-1:0] start_rate;
    logic [RATE_BITS-1:0] max_rate;
    logic [RATE_BITS-1:0] accel;
    logic                 step_in;
    logic [RATE_BITS-1:0] rate;
    logic                 busy;
    logic                 done;
    logic [STEP_BITS-1:0] steps_done;

    modport master (
        output start, stop, step_count, start_rate, max_rate, accel, step_in,
        input  rate, busy, done, steps_done
    );

    modport slave (
        input  start, stop, step_count, start_rate, max_rate, accel, step_in,
        output rate, busy, done, steps_done
    );
endinterface

// File: rtl/step_ramp_controller.sv
// Trapezoidal rate sequencer for one stepper axis: ramps the divider rate word up to cruise,
// holds, ramps back down to the start rate, and counts the step pulses the divider returns.
module step_ramp_controller #(
    parameter int unsigned RATE_BITS = 32,
    parameter int unsigned STEP_BITS = 32,
    parameter int unsigned TICK_DIV  = 1000
) (
    input logic                   clk,
    input logic                   reset,
    step_ramp_controller_if.slave bus
);
    localparam int unsigned TickBits = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {StIdle, StAccel, StCruise, StDecel, StFinish} state_e;

    state_e               state_q, state_d;
    logic [RATE_BITS-1:0] rate_q, rate_d;
    logic [RATE_BITS-1:0] start_rate_q, cruise_q, accel_q;
    logic [STEP_BITS-1:0] step_count_q;
    logic [STEP_BITS-1:0] steps_done_q, steps_done_d;
    logic [STEP_BITS-1:0] ramp_steps_q, ramp_steps_d;
    logic [TickBits-1:0]  tick_cnt_q, tick_cnt_d;
    logic                 busy_q, busy_d, done_q, done_d, stop_req_q, stop_req_d;
    logic                 step_q, step_prev_q;
    logic                 moving, tick, step_evt, latch;
    logic [RATE_BITS:0]   rate_sum;
    logic [STEP_BITS:0]   twice_steps;
    logic [STEP_BITS-1:0] remaining;

    assign moving   = (state_q == StAccel) || (state_q == StCruise) || (state_q == StDecel);
    assign latch    = (state_q == StIdle) && bus.start;
    assign tick     = moving && (tick_cnt_q == TickBits'(TICK_DIV - 1));
    assign step_evt = step_q && !step_prev_q;

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (latch) begin
            tick_cnt_d = '0;
        end else if (moving) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TickBits'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        rate_d       = rate_q;
        steps_done_d = steps_done_q;
        ramp_steps_d = ramp_steps_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        stop_req_d   = stop_req_q;
        rate_sum     = {1'b0, rate_q} + {1'b0, accel_q};

        if (moving) begin
            if (bus.stop) stop_req_d = 1'b1;
            if (step_evt && (steps_done_q != step_count_q)) begin
                steps_done_d = steps_done_q + STEP_BITS'(1);
            end
        end
        // Phase decisions look at the count including this cycle's step.
        twice_steps = {steps_done_d, 1'b0};
        remaining   = step_count_q - steps_done_d;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    busy_d       = 1'b1;
                    steps_done_d = '0;
                    ramp_steps_d = '0;
                    if (bus.step_count == '0) begin
                        state_d = StFinish;
                    end else begin
                        rate_d  = bus.start_rate;
                        state_d = StAccel;
                    end
                end
            end
            StAccel: begin
                if (step_evt) ramp_steps_d = ramp_steps_q + STEP_BITS'(1);
                if (tick) begin
                    rate_d = (rate_sum > {1'b0, cruise_q}) ? cruise_q : rate_sum[RATE_BITS-1:0];
                end
                if ((twice_steps >= {1'b0, step_count_q}) || stop_req_d) begin
                    state_d = StDecel;
                end else if (rate_d == cruise_q) begin
                    state_d = StCruise;
                end
            end
            StCruise: begin
                if ((remaining <= ramp_steps_q) || stop_req_d) state_d = StDecel;
            end
            StDecel: begin
                if (tick) begin
                    rate_d = ((rate_q - start_rate_q) > accel_q) ? rate_q - accel_q : start_rate_q;
                end
                if ((steps_done_d == step_count_q) || (stop_req_d && (rate_d == start_rate_q))) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                rate_d     = '0;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                stop_req_d = 1'b0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            rate_q       <= '0;
            steps_done_q <= '0;
            ramp_steps_q <= '0;
            tick_cnt_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            stop_req_q   <= 1'b0;
            step_q       <= 1'b0;
            step_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rate_q       <= rate_d;
            steps_done_q <= steps_done_d;
            ramp_steps_q <= ramp_steps_d;
            tick_cnt_q   <= tick_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            stop_req_q   <= stop_req_d;
            step_q       <= bus.step_in;
            step_prev_q  <= step_q;
        end
    end

    // Move parameters are frozen for the whole move.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_count_q <= '0;
            start_rate_q <= '0;
            cruise_q     <= '0;
            accel_q      <= '0;
        end else if (latch) begin
            step_count_q <= bus.step_count;
            start_rate_q <= bus.start_rate;
            cruise_q     <= (bus.max_rate > bus.start_rate) ? bus.max_rate : bus.start_rate;
            accel_q      <= bus.accel;
        end
    end

    assign bus.rate       = rate_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.steps_done = steps_done_q;
endmodule

// File: tb/tb_step_ramp_controller.sv
// Directed and randomized moves checked every cycle against a plain-arithmetic motion model.
module tb_step_ramp_controller;
    localparam int unsigned RB = 32;
    localparam int unsigned SB = 32;
    localparam int unsigned TD = 4;
    localparam int PhIdle = 0, PhUp = 1, PhHold = 2, PhDown = 3, PhFin = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    step_ramp_controller_if #(.RATE_BITS(RB), .STEP_BITS(SB)) bus ();

    step_ramp_controller #(.RATE_BITS(RB), .STEP_BITS(SB), .TICK_DIV(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model of the move, expressed as phase plus arithmetic on unbounded integers.
    int              m_phase;
    longint unsigned m_rate, m_steps, m_ramp, m_cnt, m_sr, m_acc, m_cruise, m_since;
    bit              m_busy, m_done, m_stopreq, m_s1, m_s2;

    int          step_period = 8;
    int          step_ctr = 0;
    int          done_seen = 0;
    logic [63:0] peak = '0;
    logic [63:0] last_rate = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PhIdle; m_rate = 0; m_steps = 0; m_ramp = 0; m_since = 0;
        m_busy = 0; m_done = 0; m_stopreq = 0; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic model_step();
        bit evt, tk;
        evt = m_s1 && !m_s2;
        m_s2 = m_s1;
        m_s1 = bus.step_in;
        m_done = 0;
        if (m_phase == PhIdle) begin
            if (bus.start) begin
                m_cnt = bus.step_count; m_sr = bus.start_rate; m_acc = bus.accel;
                m_cruise = (bus.max_rate > bus.start_rate) ? bus.max_rate : bus.start_rate;
                m_busy = 1; m_steps = 0; m_ramp = 0; m_since = 0;
                if (m_cnt == 0) m_phase = PhFin;
                else begin m_rate = m_sr; m_phase = PhUp; end
            end
        end else if (m_phase == PhFin) begin
            m_rate = 0; m_done = 1; m_busy = 0; m_stopreq = 0; m_phase = PhIdle;
        end else begin
            tk = (m_since % TD) == TD - 1;
            m_since++;
            if (bus.stop) m_stopreq = 1;
            if (evt && m_steps < m_cnt) m_steps++;
            case (m_phase)
                PhUp: begin
                    if (evt) m_ramp++;
                    if (tk) m_rate = (m_rate + m_acc < m_cruise) ? m_rate + m_acc : m_cruise;
                    if (2 * m_steps >= m_cnt || m_stopreq) m_phase = PhDown;
                    else if (m_rate == m_cruise) m_phase = PhHold;
                end
                PhHold: if (m_cnt - m_steps <= m_ramp || m_stopreq) m_phase = PhDown;
                PhDown: begin
                    if (tk) m_rate = (m_rate >= m_sr + m_acc) ? m_rate - m_acc : m_sr;
                    if (m_steps == m_cnt || (m_stopreq && m_rate == m_sr)) m_phase = PhFin;
                end
                default: ;
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
        check("rate", bus.rate, m_rate);
        check("busy", bus.busy, m_busy);
        check("done", bus.done, m_done);
        check("steps_done", bus.steps_done, m_steps);
        if (bus.done) done_seen++;
        if (bus.rate > peak) peak = bus.rate;
        if (bus.rate != 0) last_rate = bus.rate;
        bus.start = 0;
        bus.stop = 0;
        // Stand-in for the divider: one-cycle step pulses at a fixed period while running.
        if (m_rate != 0) begin
            bus.step_in = (step_ctr == 0);
            step_ctr = (step_ctr + 1) % step_period;
        end else begin
            bus.step_in = 0;
            step_ctr = 0;
        end
    endtask

    task automatic run_move(input string tag, input logic [63:0] cnt, input logic [63:0] sr,
                            input logic [63:0] mr, input logic [63:0] acc, input int period,
                            input int stop_pct, input bit stop_in_cruise, input bit junk_start,
                            input int limit);
        int n;
        bit stopped;
        bus.step_count = cnt[SB-1:0];
        bus.start_rate = sr[RB-1:0];
        bus.max_rate = mr[RB-1:0];
        bus.accel = acc[RB-1:0];
        step_period = period;
        peak = '0; last_rate = '0; done_seen = 0; stopped = 0; n = 0;
        bus.start = 1;
        cycle();
        while (m_phase != PhIdle && n < limit) begin
            if (stop_in_cruise && !stopped && m_phase == PhHold) begin
                bus.stop = 1;
                stopped = 1;
            end
            if (stop_pct > 0 && $urandom_range(99) < stop_pct) bus.stop = 1;
            if (junk_start && n == 10) begin
                bus.start = 1;
                bus.step_count = 3;
            end
            cycle();
            n++;
        end
        check({tag, "_bounded"}, 64'(n < limit), 1);
        cycle();
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.step_in = 0;
        bus.step_count = 0; bus.start_rate = 0; bus.max_rate = 0; bus.accel = 0;
        model_reset();
        cycle();
        cycle();
        check("reset_rate", bus.rate, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_steps", bus.steps_done, 0);
        reset = 0;

        // Abort a move during acceleration with an asynchronous reset.
        bus.step_count = 50; bus.start_rate = 10; bus.max_rate = 50; bus.accel = 10;
        step_period = 8;
        bus.start = 1;
        cycle();
        repeat (6) cycle();
        check("pre_reset_busy", bus.busy, 1);
        reset = 1;
        #1;
        check("midreset_rate", bus.rate, 0);
        check("midreset_busy", bus.busy, 0);
        check("midreset_steps", bus.steps_done, 0);
        model_reset();
        cycle();
        reset = 0;

        run_move("trap", 100, 10, 50, 10, 8, 0, 0, 0, 5000);
        check("trap_peak", peak, 50);
        check("trap_last_rate", last_rate, 10);
        check("trap_steps", bus.steps_done, 100);
        check("trap_done_once", done_seen, 1);
        check("trap_rate_idle", bus.rate, 0);

        run_move("tri", 6, 10, 50, 10, 3, 0, 0, 0, 2000);
        check("tri_below_cruise", 64'(peak < 50), 1);
        check("tri_last_rate", last_rate, 10);
        check("tri_steps", bus.steps_done, 6);
        check("tri_done_once", done_seen, 1);

        bus.step_count = 0;
        bus.start = 1;
        cycle();
        check("zero_busy", bus.busy, 1);
        check("zero_rate", bus.rate, 0);
        check("zero_no_early_done", bus.done, 0);
        cycle();
        check("zero_done", bus.done, 1);
        check("zero_busy_end", bus.busy, 0);
        check("zero_rate_end", bus.rate, 0);
        check("zero_steps", bus.steps_done, 0);
        cycle();
        check("zero_done_once", bus.done, 0);

        run_move("stop", 1000, 10, 50, 10, 8, 0, 1, 0, 5000);
        check("stop_peak", peak, 50);
        check("stop_last_rate", last_rate, 10);
        check("stop_early", 64'(bus.steps_done < 1000), 1);
        check("stop_done_once", done_seen, 1);
        check("stop_rate_idle", bus.rate, 0);

        run_move("sat", 20, 8, 64'hFFFF_FFFE, 64'h8000_0000, 40, 0, 0, 1, 5000);
        check("sat_peak", peak, 64'hFFFF_FFFE);
        check("sat_steps_latched", bus.steps_done, 20);
        check("sat_done_once", done_seen, 1);

        for (int i = 0; i < 6; i++) begin
            run_move("rnd", $urandom_range(40), $urandom_range(100, 1), $urandom_range(300),
                     $urandom_range(40), $urandom_range(12, 2), 2, 0, 1, 5000);
            check("rnd_done_once", done_seen, 1);
            check("rnd_idle", bus.busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
